// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - debounced push-key gesture classifier (short/double/long/repeat)
// One shared ms timebase and a single FSM turn a raw active-low key into one-cycle event pulses.
module key_event_ctrl #(
  parameter logic [15:0] CNT_1MS = 16'd49_999,
  parameter logic [10:0] DB_MS   = 11'd20,
  parameter logic [10:0] LONG_MS = 11'd1000,
  parameter logic [10:0] DBL_MS  = 11'd250,
  parameter logic [10:0] REP_MS  = 11'd200,
  parameter logic        DBL_EN  = 1'b1,
  parameter logic        REP_EN  = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic short_flag,
  output logic double_flag,
  output logic long_flag,
  output logic repeat_flag,
  output logic key_level
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_DN1   = 4'd1,
    S_HOLD1 = 4'd2,
    S_UP1   = 4'd3,
    S_WAIT2 = 4'd4,
    S_DN2   = 4'd5,
    S_HOLD2 = 4'd6,
    S_UP2   = 4'd7,
    S_LONG  = 4'd8,
    S_UPL   = 4'd9
  } state_t;

  state_t      r_state;
  logic        r_sync0;
  logic        r_sync1;
  logic [15:0] r_pre;
  logic [10:0] r_ms_cnt;
  logic        r_short;
  logic        r_double;
  logic        r_long;
  logic        r_repeat;
  logic        r_key_level;
  logic        w_ms_tick;
  logic        w_key_s;

  assign w_ms_tick = (r_pre == CNT_1MS);
  assign w_key_s   = r_sync1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
    end else begin
      r_sync0 <= key_in;
      r_sync1 <= r_sync0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || w_ms_tick) r_pre <= 16'd0;
    else                      r_pre <= r_pre + 16'd1;
  end

  // Key changes are tested before timeouts so an edge always wins a same-cycle expiry.
  // Any state change clears r_ms_cnt, overriding the tick increment above it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_ms_cnt    <= 11'd0;
      r_short     <= 1'b0;
      r_double    <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
      r_key_level <= 1'b0;
    end else begin
      r_short     <= 1'b0;
      r_double    <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
      r_key_level <= (r_state inside {S_HOLD1, S_UP1, S_LONG, S_UPL, S_HOLD2, S_UP2});
      if (w_ms_tick && (r_ms_cnt != 11'h7FF)) r_ms_cnt <= r_ms_cnt + 11'd1;
      case (r_state)
        S_IDLE: begin
          if (!w_key_s) begin r_state <= S_DN1; r_ms_cnt <= 11'd0; end
        end
        S_DN1: begin
          if (w_key_s) begin
            r_state <= S_IDLE; r_ms_cnt <= 11'd0;
          end else if (r_ms_cnt == DB_MS) begin
            r_state <= S_HOLD1; r_ms_cnt <= 11'd0;
          end
        end
        S_HOLD1: begin
          if (w_key_s) begin
            r_state <= S_UP1; r_ms_cnt <= 11'd0;
          end else if (r_ms_cnt == LONG_MS) begin
            r_state <= S_LONG; r_ms_cnt <= 11'd0; r_long <= 1'b1;
          end
        end
        S_UP1: begin
          if (!w_key_s) begin
            r_state <= S_HOLD1; r_ms_cnt <= 11'd0;
          end else if (r_ms_cnt == DB_MS) begin
            r_ms_cnt <= 11'd0;
            if (DBL_EN) begin
              r_state <= S_WAIT2;
            end else begin
              r_state <= S_IDLE; r_short <= 1'b1;
            end
          end
        end
        S_WAIT2: begin
          if (!w_key_s) begin
            r_state <= S_DN2; r_ms_cnt <= 11'd0;
          end else if (r_ms_cnt == DBL_MS) begin
            r_state <= S_IDLE; r_ms_cnt <= 11'd0; r_short <= 1'b1;
          end
        end
        S_DN2: begin
          if (w_key_s) begin
            r_state <= S_WAIT2; r_ms_cnt <= 11'd0;
          end else if (r_ms_cnt == DB_MS) begin
            r_state <= S_HOLD2; r_ms_cnt <= 11'd0; r_double <= 1'b1;
          end
        end
        S_HOLD2: begin
          if (w_key_s) begin r_state <= S_UP2; r_ms_cnt <= 11'd0; end
        end
        S_UP2: begin
          if (!w_key_s) begin
            r_state <= S_HOLD2; r_ms_cnt <= 11'd0;
          end else if (r_ms_cnt == DB_MS) begin
            r_state <= S_IDLE; r_ms_cnt <= 11'd0;
          end
        end
        S_LONG: begin
          if (w_key_s) begin
            r_state <= S_UPL; r_ms_cnt <= 11'd0;
          end else if (REP_EN && (r_ms_cnt == REP_MS)) begin
            r_ms_cnt <= 11'd0; r_repeat <= 1'b1;
          end
        end
        S_UPL: begin
          if (!w_key_s) begin
            r_state <= S_LONG; r_ms_cnt <= 11'd0;
          end else if (r_ms_cnt == DB_MS) begin
            r_state <= S_IDLE; r_ms_cnt <= 11'd0;
          end
        end
        default: begin
          r_state <= S_IDLE; r_ms_cnt <= 11'd0;
        end
      endcase
    end
  end

  assign short_flag  = r_short;
  assign double_flag = r_double;
  assign long_flag   = r_long;
  assign repeat_flag = r_repeat;
  assign key_level   = r_key_level;

endmodule
